idma_reg32_3d_launcher: RTL and testbench

Register-bus initiator that drives the 32-bit, 3D iDMA register frontend from the requester side. It accepts one transfer descriptor at a time and programs the configuration, address, length and per-dimension stride/repetition registers with bus writes. It launches the transfer by reading `NEXT_ID_<s>` for the selected stream, then polls `DONE_ID_<s>` until the transfer has retired. It sits between a core-side descriptor queue and the DMA's register slave port, replacing software programming of the DMA.

---
 rtl/idma_reg32_3d_launcher.sv | 230 +++++++++++++++++++++++
 tb/tb_idma_reg32_3d_launcher.sv | 622 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_reg32_3d_launcher.sv
// idma_reg32_3d_launcher: programs the 32-bit 3D iDMA register frontend
// from one descriptor, launches via NEXT_ID and polls DONE_ID to retire.
// Ports: clk_i/rst_i; desc_* descriptor in (valid/ready); reg_* bus
// initiator (valid/ready); rsp_* result out (valid/ready); busy_o.
module idma_reg32_3d_launcher #(
  parameter logic [31:0] RegBase    = 32'h0000_0000,
  parameter int unsigned NumStreams = 16,
  parameter int unsigned PollGap    = 4,
  parameter logic [31:0] PollMax    = 32'hFFFF_FFFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             desc_valid_i,
  output logic             desc_ready_o,
  input  logic [31:0]      desc_conf_i,
  input  logic [31:0]      desc_dst_i,
  input  logic [31:0]      desc_src_i,
  input  logic [31:0]      desc_len_i,
  input  logic [1:0]       desc_nd_i,
  input  logic [1:0][31:0] desc_dst_stride_i,
  input  logic [1:0][31:0] desc_src_stride_i,
  input  logic [1:0][31:0] desc_reps_i,
  input  logic [3:0]       desc_stream_i,
  output logic             reg_valid_o,
  output logic             reg_write_o,
  output logic [31:0]      reg_addr_o,
  output logic [31:0]      reg_wdata_o,
  output logic [3:0]       reg_wstrb_o,
  input  logic             reg_ready_i,
  input  logic [31:0]      reg_rdata_i,
  input  logic             reg_error_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_id_o,
  output logic             rsp_error_o,
  output logic             busy_o
);
  typedef enum logic [2:0] {
    IDLE, WR, LAUNCH, GAP, POLL, RSP
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      conf_q, dst_q;
  logic [31:0]      src_q, len_q;
  logic [1:0][31:0] dstr_q, sstr_q;
  logic [1:0][31:0] reps_q;
  logic [1:0]       nd_q;
  logic [3:0]       strm_q;
  logic [3:0]       widx_q;
  logic [31:0]      poll_q, gap_q;
  logic [31:0]      id_q;
  logic             err_q;
  // Holds desc_ready_o low for the first cycle after reset release.
  logic             live_q;

  logic        accept, req, hs;
  logic        strm_bad, last_wr;
  logic        done, poll_hit, gap_end;
  logic [31:0] diff, poll_nx;
  logic [31:0] wr_off, wr_data, strm_off;

  assign accept   = (state_q == IDLE) & live_q
                  & desc_valid_i;
  assign req      = (state_q == WR)
                  | (state_q == LAUNCH)
                  | (state_q == POLL);
  assign hs       = req & reg_ready_i;
  assign strm_bad = 32'(desc_stream_i) >= NumStreams;
  assign last_wr  = widx_q == 4'd3 + 4'd3 * {2'b00, nd_q};
  // Modular compare keeps working across ID wrap-around.
  assign diff     = reg_rdata_i - id_q;
  assign done     = ~diff[31];
  assign poll_nx  = poll_q + 32'd1;
  assign poll_hit = poll_nx == PollMax;
  assign gap_end  = gap_q == PollGap - 32'd1;
  assign strm_off = {26'd0, strm_q, 2'b00};

  // Dimension registers sit at 0xE0 + 4*(widx-4).
  always_comb begin
    wr_off  = 32'h00;
    wr_data = conf_q;
    case (widx_q)
      4'd1: begin wr_off = 32'hD0; wr_data = dst_q; end
      4'd2: begin wr_off = 32'hD4; wr_data = src_q; end
      4'd3: begin wr_off = 32'hD8; wr_data = len_q; end
      4'd4: begin wr_off = 32'hE0; wr_data = dstr_q[0]; end
      4'd5: begin wr_off = 32'hE4; wr_data = sstr_q[0]; end
      4'd6: begin wr_off = 32'hE8; wr_data = reps_q[0]; end
      4'd7: begin wr_off = 32'hEC; wr_data = dstr_q[1]; end
      4'd8: begin wr_off = 32'hF0; wr_data = sstr_q[1]; end
      4'd9: begin wr_off = 32'hF4; wr_data = reps_q[1]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (accept) state_d = strm_bad ? RSP : WR;
      WR:
        if (hs) begin
          if (reg_error_i)  state_d = RSP;
          else if (last_wr) state_d = LAUNCH;
        end
      LAUNCH:
        if (hs) state_d = reg_error_i ? RSP : POLL;
      POLL:
        if (hs) begin
          if (reg_error_i | done | poll_hit)
            state_d = RSP;
          else if (PollGap == 0)
            state_d = POLL;
          else
            state_d = GAP;
        end
      GAP:
        if (gap_end) state_d = POLL;
      RSP:
        if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conf_q <= '0;
      dst_q  <= '0;
      src_q  <= '0;
      len_q  <= '0;
      dstr_q <= '0;
      sstr_q <= '0;
      reps_q <= '0;
      nd_q   <= '0;
      strm_q <= '0;
      widx_q <= '0;
      poll_q <= '0;
      gap_q  <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (accept) begin
            conf_q <= desc_conf_i;
            dst_q  <= desc_dst_i;
            src_q  <= desc_src_i;
            len_q  <= desc_len_i;
            dstr_q <= desc_dst_stride_i;
            sstr_q <= desc_src_stride_i;
            reps_q <= desc_reps_i;
            nd_q   <= (desc_nd_i == 2'd3) ? 2'd2
                                          : desc_nd_i;
            strm_q <= desc_stream_i;
            widx_q <= '0;
            poll_q <= '0;
            gap_q  <= '0;
            id_q   <= '0;
            err_q  <= strm_bad;
          end
        WR:
          if (hs) begin
            widx_q <= widx_q + 4'd1;
            if (reg_error_i) err_q <= 1'b1;
          end
        LAUNCH:
          if (hs) begin
            if (reg_error_i) err_q <= 1'b1;
            else             id_q  <= reg_rdata_i;
            poll_q <= '0;
          end
        POLL:
          if (hs) begin
            if (reg_error_i) begin
              err_q <= 1'b1;
            end else if (!done) begin
              poll_q <= poll_nx;
              gap_q  <= '0;
              if (poll_hit) err_q <= 1'b1;
            end
          end
        GAP:
          gap_q <= gap_q + 32'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    reg_wstrb_o = '0;
    unique case (1'b1)
      state_q == WR: begin
        reg_valid_o = 1'b1;
        reg_write_o = 1'b1;
        reg_addr_o  = RegBase + wr_off;
        reg_wdata_o = wr_data;
        reg_wstrb_o = 4'hF;
      end
      state_q == LAUNCH: begin
        reg_valid_o = 1'b1;
        reg_addr_o  = RegBase + 32'h44 + strm_off;
      end
      state_q == POLL: begin
        reg_valid_o = 1'b1;
        reg_addr_o  = RegBase + 32'h84 + strm_off;
      end
      default: ;
    endcase
    desc_ready_o = (state_q == IDLE) & live_q;
    busy_o       = state_q != IDLE;
    rsp_valid_o  = state_q == RSP;
    rsp_id_o     = id_q;
    rsp_error_o  = err_q;
  end
endmodule

// File: tb/tb_idma_reg32_3d_launcher.sv
// tb_idma_reg32_3d_launcher: randomized bench with a register-slave
// model and a transfer-level reference for writes, polls and results.
module tb_idma_reg32_3d_launcher;
  localparam int unsigned NS = 8;
  localparam int unsigned PG = 2;
  localparam logic [31:0] PM = 32'd3;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic desc_valid_i = 1'b0;
  logic desc_ready_o;
  logic [31:0] desc_conf_i = '0;
  logic [31:0] desc_dst_i = '0;
  logic [31:0] desc_src_i = '0;
  logic [31:0] desc_len_i = '0;
  logic [1:0] desc_nd_i = '0;
  logic [1:0][31:0] desc_dst_stride_i = '0;
  logic [1:0][31:0] desc_src_stride_i = '0;
  logic [1:0][31:0] desc_reps_i = '0;
  logic [3:0] desc_stream_i = '0;
  logic reg_valid_o, reg_write_o;
  logic [31:0] reg_addr_o, reg_wdata_o;
  logic [3:0] reg_wstrb_o;
  logic reg_ready_i, reg_error_i;
  logic [31:0] reg_rdata_i;
  logic rsp_valid_o;
  logic rsp_ready_i = 1'b0;
  logic [31:0] rsp_id_o;
  logic rsp_error_o, busy_o;

  idma_reg32_3d_launcher #(
    .RegBase(32'h0), .NumStreams(NS),
    .PollGap(PG), .PollMax(PM)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .desc_valid_i(desc_valid_i),
    .desc_ready_o(desc_ready_o),
    .desc_conf_i(desc_conf_i),
    .desc_dst_i(desc_dst_i),
    .desc_src_i(desc_src_i),
    .desc_len_i(desc_len_i),
    .desc_nd_i(desc_nd_i),
    .desc_dst_stride_i(desc_dst_stride_i),
    .desc_src_stride_i(desc_src_stride_i),
    .desc_reps_i(desc_reps_i),
    .desc_stream_i(desc_stream_i),
    .reg_valid_o(reg_valid_o),
    .reg_write_o(reg_write_o),
    .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready_i),
    .reg_rdata_i(reg_rdata_i),
    .reg_error_i(reg_error_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o),
    .rsp_error_o(rsp_error_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model configuration (written by tasks only)
  bit rand_ready = 1'b0;
  bit stall_en = 1'b0;
  bit err_en = 1'b0;
  logic [31:0] stall_addr = '0;
  logic [31:0] err_addr = '0;
  logic [31:0] nid = '0;
  logic [31:0] done_vals[$];
  int done_base = 0;
  int c0 = 0;
  int base = 0;

  // slave model state (written by the slave only)
  int done_cnt = 0;
  int viol = 0;
  bit pend = 1'b0;
  logic [31:0] p_addr, p_data;
  logic p_wr;
  logic [3:0] p_strb;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  bit log_wr[$];
  logic [3:0] log_strb[$];
  int log_cyc[$];

  // expected write list
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  always @(negedge clk) begin : slave
    logic rdy, er;
    logic [31:0] rd, na, da;
    int k;
    rdy = 1'b0;
    er = 1'b0;
    rd = '0;
    na = 32'h44 + {26'd0, desc_stream_i, 2'b00};
    da = 32'h84 + {26'd0, desc_stream_i, 2'b00};
    if (rst_i) begin
      pend <= 1'b0;
      reg_ready_i <= 1'b0;
      reg_error_i <= 1'b0;
      reg_rdata_i <= '0;
    end else if (!reg_valid_o) begin
      if (pend) viol <= viol + 1;
      pend <= 1'b0;
      reg_ready_i <= 1'b0;
      reg_error_i <= 1'b0;
      reg_rdata_i <= '0;
    end else begin
      if (pend && (reg_addr_o !== p_addr ||
          reg_wdata_o !== p_data ||
          reg_write_o !== p_wr ||
          reg_wstrb_o !== p_strb))
        viol <= viol + 1;
      if (stall_en && reg_addr_o == stall_addr)
        rdy = 1'b0;
      else if (rand_ready)
        rdy = ($urandom_range(0, 3) != 0);
      else
        rdy = 1'b1;
      if (reg_addr_o == na) begin
        rd = nid;
      end else if (reg_addr_o == da &&
                   done_vals.size() > 0) begin
        k = done_cnt - done_base;
        if (k >= done_vals.size())
          k = done_vals.size() - 1;
        rd = done_vals[k];
        if (rdy) done_cnt <= done_cnt + 1;
      end
      er = rdy && err_en && reg_addr_o == err_addr;
      reg_ready_i <= rdy;
      reg_error_i <= er;
      reg_rdata_i <= rd;
      if (rdy) begin
        log_addr.push_back(reg_addr_o);
        log_data.push_back(reg_wdata_o);
        log_wr.push_back(reg_write_o);
        log_strb.push_back(reg_wstrb_o);
        log_cyc.push_back(cyc);
      end
      pend <= !rdy;
      p_addr <= reg_addr_o;
      p_data <= reg_wdata_o;
      p_wr <= reg_write_o;
      p_strb <= reg_wstrb_o;
    end
  end

  // ---------------- reference model ----------------
  function automatic void build_exp();
    int n;
    n = (desc_nd_i == 2'd3) ? 2 : int'(desc_nd_i);
    exp_a.delete();
    exp_d.delete();
    exp_a.push_back(32'h00); exp_d.push_back(desc_conf_i);
    exp_a.push_back(32'hD0); exp_d.push_back(desc_dst_i);
    exp_a.push_back(32'hD4); exp_d.push_back(desc_src_i);
    exp_a.push_back(32'hD8); exp_d.push_back(desc_len_i);
    for (int d = 0; d < n; d++) begin
      exp_a.push_back(32'(32'hE0 + 12 * d));
      exp_d.push_back(desc_dst_stride_i[d]);
      exp_a.push_back(32'(32'hE4 + 12 * d));
      exp_d.push_back(desc_src_stride_i[d]);
      exp_a.push_back(32'(32'hE8 + 12 * d));
      exp_d.push_back(desc_reps_i[d]);
    end
  endfunction

  function automatic void poll_model(
    output int polls, output bit err);
    logic [31:0] v;
    int k;
    polls = 0;
    err = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      k = (i < done_vals.size()) ? i
                                 : done_vals.size() - 1;
      v = done_vals[k];
      polls++;
      if ($signed(v - nid) >= 0) return;
      if (polls == int'(PM)) begin
        err = 1'b1;
        return;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic rand_desc(input logic [3:0] s,
                           input logic [1:0] nd);
    desc_conf_i = $urandom;
    desc_dst_i = $urandom;
    desc_src_i = $urandom;
    desc_len_i = $urandom;
    for (int d = 0; d < 2; d++) begin
      desc_dst_stride_i[d] = $urandom;
      desc_src_stride_i[d] = $urandom;
      desc_reps_i[d] = $urandom;
    end
    desc_stream_i = s;
    desc_nd_i = nd;
  endtask

  task automatic send();
    int n;
    n = 0;
    @(negedge clk);
    while (!desc_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    desc_valid_i = 1'b1;
    c0 = cyc;
    base = log_addr.size();
    done_base = done_cnt;
    @(negedge clk);
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int rc,
                          output logic [31:0] id,
                          output logic er,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rc = cyc - c0;
    id = rsp_id_o;
    er = rsp_error_o;
    if (ok) begin
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (reg_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_bus valid=%b busy=%b exp 0/0",
               reg_valid_o, busy_o);
    end
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_id_o !== 32'h0 ||
        rsp_error_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_rsp v=%b id=%h e=%b exp 0/0/0",
               rsp_valid_o, rsp_id_o, rsp_error_o);
    end
    @(negedge clk);
    #1 rst_i = 1'b0;
    checks++;
    if (desc_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready_early got=%b exp=0",
               desc_ready_o);
    end
    @(negedge clk);
    checks++;
    if (desc_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready_rise got=%b exp=1",
               desc_ready_o);
    end
  endtask

  task automatic test_1d();
    int rc, w, j, ec;
    logic [31:0] id, ea;
    logic er, ew;
    bit ok;
    rand_ready = 1'b0;
    rand_desc(4'd0, 2'd0);
    nid = 32'd7;
    done_vals.delete();
    done_vals.push_back(32'd7);
    send();
    wait_rsp(rc, id, er, ok);
    build_exp();
    w = exp_a.size();
    checks++;
    if (log_addr.size() - base !== w + 2) begin
      failures++;
      $display("FAIL 1d_count got=%0d exp=%0d",
               log_addr.size() - base, w + 2);
    end
    for (int i = 0; i < w + 2; i++) begin
      j = base + i;
      ea = (i < w) ? exp_a[i]
         : (i == w) ? 32'h44 : 32'h84;
      ew = (i < w);
      ec = i + 1;
      if (j < log_addr.size()) begin
        checks++;
        if (log_addr[j] !== ea || log_wr[j] !== ew ||
            log_strb[j] !== (ew ? 4'hF : 4'h0) ||
            (ew && log_data[j] !== exp_d[i]) ||
            log_cyc[j] - c0 !== ec) begin
          failures++;
          $display("FAIL 1d_req%0d a=%h c=%0d exp a=%h c=%0d",
                   i, log_addr[j], log_cyc[j] - c0, ea, ec);
        end
      end
    end
    checks++;
    if (!ok || rc !== 7 || id !== 32'd7 || er !== 1'b0) begin
      failures++;
      $display("FAIL 1d_rsp ok=%b c=%0d id=%h e=%b exp 1/7/7/0",
               ok, rc, id, er);
    end
  endtask

  task automatic test_3d_stalls();
    int rc, w, j, ep, n;
    logic [31:0] id, ea;
    logic er;
    bit ok, ee;
    rand_ready = 1'b1;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) rand_desc(4'd3, 2'd2);
      else rand_desc(4'($urandom_range(0, NS - 1)),
                     2'($urandom_range(0, 3)));
      nid = $urandom;
      done_vals.delete();
      n = $urandom_range(0, 2);
      for (int f = 0; f < n; f++)
        done_vals.push_back(
          nid - 32'($urandom_range(1, 1000)));
      done_vals.push_back(
        nid + 32'($urandom_range(0, 1000)));
      send();
      wait_rsp(rc, id, er, ok);
      build_exp();
      poll_model(ep, ee);
      w = exp_a.size();
      checks++;
      if (log_addr.size() - base !== w + 1 + ep) begin
        failures++;
        $display("FAIL 3d_count it=%0d got=%0d exp=%0d", it,
                 log_addr.size() - base, w + 1 + ep);
      end
      for (int i = 0; i < w + 1 + ep; i++) begin
        j = base + i;
        ea = (i < w) ? exp_a[i]
           : (i == w) ? 32'h44 + 4 * desc_stream_i
           : 32'h84 + 4 * desc_stream_i;
        if (j < log_addr.size()) begin
          checks++;
          if (log_addr[j] !== ea ||
              log_wr[j] !== (i < w) ||
              (i < w && log_data[j] !== exp_d[i])) begin
            failures++;
            $display("FAIL 3d_req it=%0d i=%0d a=%h exp a=%h",
                     it, i, log_addr[j], ea);
          end
        end
      end
      checks++;
      if (!ok || id !== nid || er !== ee) begin
        failures++;
        $display("FAIL 3d_rsp it=%0d id=%h e=%b exp id=%h e=%b",
                 it, id, er, nid, ee);
      end
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL req_stability got=%0d exp=0", viol);
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int rc, w, j, ec;
    logic [31:0] id;
    logic er;
    bit ok;
    rand_ready = 1'b0;
    rand_desc(4'($urandom_range(0, NS - 1)),
              2'($urandom_range(0, 2)));
    nid = 32'hFFFF_FFFE;
    done_vals.delete();
    done_vals.push_back(32'hFFFF_FFFD);
    done_vals.push_back(32'hFFFF_FFFD);
    done_vals.push_back(32'h0000_0001);
    send();
    wait_rsp(rc, id, er, ok);
    build_exp();
    w = exp_a.size();
    checks++;
    if (log_addr.size() - base !== w + 4) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=%0d",
               log_addr.size() - base, w + 4);
    end
    for (int p = 0; p < 3; p++) begin
      j = base + w + 1 + p;
      ec = w + 2 + p * (1 + PG);
      if (j < log_addr.size()) begin
        checks++;
        if (log_addr[j] !== 32'h84 + 4 * desc_stream_i ||
            log_cyc[j] - c0 !== ec) begin
          failures++;
          $display("FAIL wrap_poll%0d a=%h c=%0d exp c=%0d",
                   p, log_addr[j], log_cyc[j] - c0, ec);
        end
      end
    end
    checks++;
    if (!ok || rc !== w + 9 || id !== nid || er !== 1'b0) begin
      failures++;
      $display("FAIL wrap_rsp c=%0d id=%h e=%b exp c=%0d id=%h e=0",
               rc, id, er, w + 9, nid);
    end
  endtask

  task automatic test_bus_error();
    int rc;
    logic [31:0] id;
    logic er;
    bit ok;
    rand_ready = 1'b0;
    rand_desc(4'd1, 2'd1);
    nid = $urandom;
    done_vals.delete();
    done_vals.push_back(nid);
    err_en = 1'b1;
    err_addr = 32'hD4;
    send();
    wait_rsp(rc, id, er, ok);
    err_en = 1'b0;
    checks++;
    if (log_addr.size() - base !== 3) begin
      failures++;
      $display("FAIL berr_count got=%0d exp=3",
               log_addr.size() - base);
    end
    checks++;
    if (!ok || id !== 32'h0 || er !== 1'b1 || rc !== 4) begin
      failures++;
      $display("FAIL berr_rsp c=%0d id=%h e=%b exp c=4 id=0 e=1",
               rc, id, er);
    end
    rand_desc(4'd12, 2'($urandom_range(0, 3)));
    send();
    wait_rsp(rc, id, er, ok);
    checks++;
    if (log_addr.size() - base !== 0) begin
      failures++;
      $display("FAIL strm_count got=%0d exp=0",
               log_addr.size() - base);
    end
    checks++;
    if (!ok || rc !== 1 || id !== 32'h0 || er !== 1'b1) begin
      failures++;
      $display("FAIL strm_rsp c=%0d id=%h e=%b exp c=1 id=0 e=1",
               rc, id, er);
    end
  endtask

  task automatic test_timeout_backpressure();
    int rc, w;
    bit ok;
    rand_ready = 1'b0;
    rand_desc(4'($urandom_range(0, NS - 1)),
              2'($urandom_range(0, 3)));
    nid = $urandom;
    done_vals.delete();
    done_vals.push_back(nid - 32'($urandom_range(1, 500)));
    send();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rc = cyc - c0;
    build_exp();
    w = exp_a.size();
    checks++;
    if (log_addr.size() - base !== w + 4) begin
      failures++;
      $display("FAIL tmo_count got=%0d exp=%0d",
               log_addr.size() - base, w + 4);
    end
    checks++;
    if (!ok || rc !== w + 9) begin
      failures++;
      $display("FAIL tmo_cycle ok=%b got=%0d exp=%0d",
               ok, rc, w + 9);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== nid ||
          rsp_error_o !== 1'b1 || desc_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL tmo_hold%0d v=%b id=%h e=%b r=%b exp 1/%h/1/0",
                 i, rsp_valid_o, rsp_id_o, rsp_error_o,
                 desc_ready_o, nid);
      end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || desc_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL tmo_release v=%b r=%b exp 0/1",
               rsp_valid_o, desc_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int rc, w;
    logic [31:0] id;
    logic er;
    bit ok, seen;
    rand_ready = 1'b0;
    rand_desc(4'($urandom_range(0, NS - 1)),
              2'($urandom_range(0, 3)));
    nid = $urandom;
    done_vals.delete();
    done_vals.push_back(nid);
    stall_en = 1'b1;
    stall_addr = 32'hD8;
    send();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (reg_valid_o && reg_addr_o == 32'hD8) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_len_seen got=0 exp=1");
    end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (reg_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_drop valid=%b busy=%b exp 0/0",
               reg_valid_o, busy_o);
    end
    #1 rst_i = 1'b0;
    stall_en = 1'b0;
    @(negedge clk);
    checks++;
    if (desc_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready got=%b exp=1", desc_ready_o);
    end
    rand_desc(4'($urandom_range(0, NS - 1)),
              2'($urandom_range(0, 3)));
    nid = $urandom;
    done_vals.delete();
    done_vals.push_back(nid);
    send();
    wait_rsp(rc, id, er, ok);
    build_exp();
    w = exp_a.size();
    checks++;
    if (log_addr.size() - base !== w + 2 ||
        log_addr[base] !== 32'h00 ||
        log_data[base] !== desc_conf_i ||
        log_cyc[base] - c0 !== 1) begin
      failures++;
      $display("FAIL mid_restart n=%0d a=%h exp n=%0d a=0",
               log_addr.size() - base, log_addr[base], w + 2);
    end
    checks++;
    if (!ok || id !== nid || er !== 1'b0 || rc !== w + 3) begin
      failures++;
      $display("FAIL mid_rsp c=%0d id=%h e=%b exp c=%0d id=%h e=0",
               rc, id, er, w + 3, nid);
    end
  endtask

  initial begin
    test_reset();
    test_1d();
    test_3d_stalls();
    test_wrap();
    test_bus_error();
    test_timeout_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
